// File: rtl/sc_game_pkg.sv
// Shared game definitions for the Frogger datapath: game-state codes driven by
// the top-level game FSM, the level-counter FSM encoding, and a parameter
// legality helper for the level counter.
package sc_game_pkg;

  // Width of the game-state bus shared between the game FSM and its consumers.
  localparam int STATE_WIDTH = 2;

  // Game-state codes as broadcast by the top-level game FSM.
  typedef enum logic [STATE_WIDTH-1:0] {
    AWAITSTART = 2'd0,
    STARTGAME  = 2'd1,
    ENDGAME    = 2'd2,
    RESERVED   = 2'd3
  } gameState_t;

  // Level-counter FSM encoding.
  typedef enum logic [1:0] {
    LC_IDLE = 2'd0,
    LC_PLAY = 2'd1,
    LC_WIN  = 2'd2,
    LC_HOLD = 2'd3
  } lcState_t;

  // True when a level-counter configuration is usable: width 2..8, the top
  // level representable in that width, and the start level inside the range.
  function automatic bit levelParamsLegal(int levelWidth, int levelMax, int startLevel);
    return (levelWidth >= 2) && (levelWidth <= 8) &&
           (levelMax >= 0) && (levelMax < (1 << levelWidth)) &&
           (startLevel >= 0) && (startLevel <= levelMax);
  endfunction

endpackage

// File: rtl/sc_negedge_detect.sv
// Falling-edge detector for an active-low, clock-synchronous strobe. The
// previous-sample register resets to the inactive (high) level, and the pulse
// is high for the single cycle in which a high-to-low transition is observed.
module sc_negedge_detect (
  input  logic SC_NEGEDGE_DETECT_CLOCK_50,
  input  logic SC_NEGEDGE_DETECT_RESET_InHigh,
  input  logic SC_NEGEDGE_DETECT_Signal_InLow,
  output logic SC_NEGEDGE_DETECT_Pulse_OutHigh
);

  logic signalPrev_reg;

  // Track the last sampled strobe level every clock, whatever the consumer is doing.
  always_ff @(posedge SC_NEGEDGE_DETECT_CLOCK_50 or posedge SC_NEGEDGE_DETECT_RESET_InHigh) begin
    if (SC_NEGEDGE_DETECT_RESET_InHigh) begin
      signalPrev_reg <= 1'b1;
    end else begin
      signalPrev_reg <= SC_NEGEDGE_DETECT_Signal_InLow;
    end
  end

  // A held-low strobe yields one pulse because prev follows it low after one cycle.
  assign SC_NEGEDGE_DETECT_Pulse_OutHigh = signalPrev_reg & ~SC_NEGEDGE_DETECT_Signal_InLow;

endmodule

// File: rtl/sc_levelcounter_param.sv
// Parametrised game-level counter. Counts falling edges of the active-low
// level-cleared strobe while the game is in STARTGAME, saturating with a
// sticky win flag or wrapping back to the start level at the top of range.
// All outputs are registered; the level and level-up pulse follow a sampled
// strobe edge by one clock.
module sc_levelcounter_param
  import sc_game_pkg::*;
#(
  parameter int CURRENTSTATE_DATAWIDTH = 2,
  parameter int LEVEL_DATAWIDTH        = 3,
  parameter int LEVEL_MAX              = 4,
  parameter int START_LEVEL            = 0,
  parameter int WRAP_MODE              = 0
) (
  input  logic                              SC_LEVELCOUNTER_CLOCK_50,
  input  logic                              SC_LEVELCOUNTER_RESET_InHigh,
  input  logic [CURRENTSTATE_DATAWIDTH-1:0] SC_LEVELCOUNTER_CurrentState_InBus,
  input  logic                              SC_LEVELCOUNTER_CountSignal_InLow,
  output logic [LEVEL_DATAWIDTH-1:0]        SC_LEVELCOUNTER_Data_OutBus,
  output logic                              SC_LEVELCOUNTER_LevelUp_OutHigh,
  output logic                              SC_LEVELCOUNTER_Win_OutHigh
);

  // Refuse to build a counter whose range cannot be represented.
  generate
    if (!levelParamsLegal(LEVEL_DATAWIDTH, LEVEL_MAX, START_LEVEL)) begin : gParamGuard
      $error("sc_levelcounter_param: illegal LEVEL_DATAWIDTH/LEVEL_MAX/START_LEVEL combination");
    end
  endgenerate

  localparam logic [LEVEL_DATAWIDTH-1:0]        LEVEL_MAX_V  = LEVEL_DATAWIDTH'(LEVEL_MAX);
  localparam logic [LEVEL_DATAWIDTH-1:0]        LEVEL_START_V = LEVEL_DATAWIDTH'(START_LEVEL);
  localparam logic [CURRENTSTATE_DATAWIDTH-1:0] CODE_START   = CURRENTSTATE_DATAWIDTH'(STARTGAME);
  localparam logic [CURRENTSTATE_DATAWIDTH-1:0] CODE_END     = CURRENTSTATE_DATAWIDTH'(ENDGAME);
  localparam bit                                WRAP_EN      = (WRAP_MODE != 0);

  lcState_t                   state_reg, state_next;
  logic [LEVEL_DATAWIDTH-1:0] levelData_reg, levelData_next;
  logic                       levelUp_reg, levelUp_next;
  logic                       win_reg, win_next;

  logic                       countEvent;
  logic                       gameStarted;
  logic                       gameEnded;
  logic [LEVEL_DATAWIDTH-1:0] levelInc;

  sc_negedge_detect uStrobeEdge (
    .SC_NEGEDGE_DETECT_CLOCK_50      (SC_LEVELCOUNTER_CLOCK_50),
    .SC_NEGEDGE_DETECT_RESET_InHigh  (SC_LEVELCOUNTER_RESET_InHigh),
    .SC_NEGEDGE_DETECT_Signal_InLow  (SC_LEVELCOUNTER_CountSignal_InLow),
    .SC_NEGEDGE_DETECT_Pulse_OutHigh (countEvent)
  );

  assign gameStarted = (SC_LEVELCOUNTER_CurrentState_InBus == CODE_START);
  assign gameEnded   = (SC_LEVELCOUNTER_CurrentState_InBus == CODE_END);
  // Cannot overflow: LEVEL_MAX is representable and we only increment below it.
  assign levelInc    = levelData_reg + LEVEL_DATAWIDTH'(1);

  // Next-state and next-output decisions; game-state changes take priority over strobe edges.
  always_comb begin
    state_next     = state_reg;
    levelData_next = levelData_reg;
    levelUp_next   = 1'b0;
    win_next       = win_reg;

    unique case (state_reg)
      LC_IDLE: begin
        levelData_next = LEVEL_START_V;
        win_next       = 1'b0;
        if (gameStarted) begin
          state_next = LC_PLAY;
        end
      end

      LC_PLAY: begin
        if (gameEnded) begin
          state_next = LC_HOLD;
        end else if (!gameStarted) begin
          state_next = LC_IDLE;
        end else if (countEvent) begin
          if (levelData_reg < LEVEL_MAX_V) begin
            levelData_next = levelInc;
            levelUp_next   = 1'b1;
            // Reaching the top in saturate mode is itself the win.
            if (!WRAP_EN && (levelInc == LEVEL_MAX_V)) begin
              win_next   = 1'b1;
              state_next = LC_WIN;
            end
          end else if (WRAP_EN) begin
            levelData_next = LEVEL_START_V;
            levelUp_next   = 1'b1;
          end else begin
            win_next   = 1'b1;
            state_next = LC_WIN;
          end
        end
      end

      LC_WIN: begin
        if (gameEnded) begin
          state_next = LC_HOLD;
        end else if (!gameStarted) begin
          state_next = LC_IDLE;
        end
      end

      LC_HOLD: begin
        if (gameStarted) begin
          state_next = LC_PLAY;
        end else if (!gameEnded) begin
          state_next = LC_IDLE;
        end
      end

      default: begin
        state_next = LC_IDLE;
      end
    endcase
  end

  // Register FSM state and every output; reset clears immediately to level 0, not START_LEVEL.
  always_ff @(posedge SC_LEVELCOUNTER_CLOCK_50 or posedge SC_LEVELCOUNTER_RESET_InHigh) begin
    if (SC_LEVELCOUNTER_RESET_InHigh) begin
      state_reg     <= LC_IDLE;
      levelData_reg <= '0;
      levelUp_reg   <= 1'b0;
      win_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      levelData_reg <= levelData_next;
      levelUp_reg   <= levelUp_next;
      win_reg       <= win_next;
    end
  end

  assign SC_LEVELCOUNTER_Data_OutBus     = levelData_reg;
  assign SC_LEVELCOUNTER_LevelUp_OutHigh = levelUp_reg;
  assign SC_LEVELCOUNTER_Win_OutHigh     = win_reg;

endmodule

// File: tb/tb_sc_levelcounter_param.sv
// Bench for sc_levelcounter_param: two instances (saturating and wrapping)
// share one stimulus stream. A behavioural model of the level rules is checked
// against both on every falling clock edge, and hand-computed literal values
// pin the model at the end of each directed phase.
module tb_sc_levelcounter_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] gs  = 2'd0;
  logic       cs  = 1'b0;

  logic [2:0] dataS, dataW;
  logic       upS, upW, winS, winW;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  sc_levelcounter_param #(
    .CURRENTSTATE_DATAWIDTH(2), .LEVEL_DATAWIDTH(3), .LEVEL_MAX(4), .START_LEVEL(0), .WRAP_MODE(0)
  ) dutSat (
    .SC_LEVELCOUNTER_CLOCK_50           (clk),
    .SC_LEVELCOUNTER_RESET_InHigh       (rst),
    .SC_LEVELCOUNTER_CurrentState_InBus (gs),
    .SC_LEVELCOUNTER_CountSignal_InLow  (cs),
    .SC_LEVELCOUNTER_Data_OutBus        (dataS),
    .SC_LEVELCOUNTER_LevelUp_OutHigh    (upS),
    .SC_LEVELCOUNTER_Win_OutHigh        (winS)
  );

  sc_levelcounter_param #(
    .CURRENTSTATE_DATAWIDTH(2), .LEVEL_DATAWIDTH(3), .LEVEL_MAX(3), .START_LEVEL(1), .WRAP_MODE(1)
  ) dutWrap (
    .SC_LEVELCOUNTER_CLOCK_50           (clk),
    .SC_LEVELCOUNTER_RESET_InHigh       (rst),
    .SC_LEVELCOUNTER_CurrentState_InBus (gs),
    .SC_LEVELCOUNTER_CountSignal_InLow  (cs),
    .SC_LEVELCOUNTER_Data_OutBus        (dataW),
    .SC_LEVELCOUNTER_LevelUp_OutHigh    (upW),
    .SC_LEVELCOUNTER_Win_OutHigh        (winW)
  );

  // Model configuration: index 0 = saturating instance, 1 = wrapping instance.
  int mMax[2]   = '{4, 3};
  int mStart[2] = '{0, 1};
  bit mWrap[2]  = '{1'b0, 1'b1};

  // Model state: level, pulse, win, last strobe level, and whether the
  // counter is counting / frozen-after-win / frozen-at-end / idle.
  int mLvl[2];
  bit mUp[2], mWin[2], mPrev[2];
  bit mCounting[2], mWon[2], mFrozen[2];

  int upCnt[2] = '{0, 0};

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the level rules.
  initial begin
    for (int k = 0; k < 2; k++) begin
      mLvl[k] = 0; mUp[k] = 0; mWin[k] = 0; mPrev[k] = 1;
      mCounting[k] = 0; mWon[k] = 0; mFrozen[k] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          mLvl[k] = 0; mUp[k] = 0; mWin[k] = 0; mPrev[k] = 1;
          mCounting[k] = 0; mWon[k] = 0; mFrozen[k] = 0;
        end else begin
          bit ev;
          bit idle;
          ev = mPrev[k] && !cs;
          mPrev[k] = cs;
          mUp[k] = 0;
          idle = !mCounting[k] && !mWon[k] && !mFrozen[k];
          if (idle) begin
            mLvl[k] = mStart[k];
            mWin[k] = 0;
            if (gs == 2'd1) mCounting[k] = 1;
          end else if (gs == 2'd2) begin
            // end of game: freeze, whatever we were doing
            mCounting[k] = 0; mWon[k] = 0; mFrozen[k] = 1;
          end else if (gs != 2'd1) begin
            mCounting[k] = 0; mWon[k] = 0; mFrozen[k] = 0;
          end else if (mFrozen[k]) begin
            mFrozen[k] = 0; mCounting[k] = 1;
          end else if (mCounting[k] && ev) begin
            if (mLvl[k] < mMax[k]) begin
              mLvl[k] = mLvl[k] + 1;
              mUp[k] = 1;
            end else if (mWrap[k]) begin
              mLvl[k] = mStart[k];
              mUp[k] = 1;
            end
            if (!mWrap[k] && mLvl[k] == mMax[k]) begin
              mWin[k] = 1; mCounting[k] = 0; mWon[k] = 1;
            end
          end
        end
      end
    end
  end

  // Compare process: every falling edge, both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("sat.data", int'(dataS), mLvl[0]);
      chk("sat.levelup", int'(upS), int'(mUp[0]));
      chk("sat.win", int'(winS), int'(mWin[0]));
      chk("wrap.data", int'(dataW), mLvl[1]);
      chk("wrap.levelup", int'(upW), int'(mUp[1]));
      chk("wrap.win", int'(winW), int'(mWin[1]));
      upCnt[0] += int'(upS);
      upCnt[1] += int'(upW);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic strobe();
    cs = 1'b0; tick(1);
    cs = 1'b1; tick(2);
  endtask

  int baseS, baseW;

  initial begin
    // T1: reset with strobe held low, release while still low.
    tick(3);
    chk("t1.rst.dataS", int'(dataS), 0);
    chk("t1.rst.dataW", int'(dataW), 0);
    chk("t1.rst.upS", int'(upS), 0);
    chk("t1.rst.winS", int'(winS), 0);
    rst = 1'b0;
    tick(3);
    chk("t1.idle.dataS", int'(dataS), 0);
    chk("t1.idle.dataW", int'(dataW), 1);
    chk("t1.idle.upcnt", upCnt[0] + upCnt[1], 0);
    cs = 1'b1; gs = 2'd1; tick(2);

    // T2: three single-cycle strobes.
    baseS = upCnt[0]; baseW = upCnt[1];
    repeat (3) strobe();
    chk("t2.dataS", int'(dataS), 3);
    chk("t2.dataW", int'(dataW), 1);
    chk("t2.pulsesS", upCnt[0] - baseS, 3);
    chk("t2.pulsesW", upCnt[1] - baseW, 3);
    gs = 2'd0; tick(2);
    chk("t2.idle.dataS", int'(dataS), 0);
    gs = 2'd1; tick(2);

    // T3: strobe held low for 20 cycles counts once.
    baseS = upCnt[0]; baseW = upCnt[1];
    cs = 1'b0; tick(20);
    cs = 1'b1; tick(2);
    chk("t3.dataS", int'(dataS), 1);
    chk("t3.dataW", int'(dataW), 2);
    chk("t3.pulsesS", upCnt[0] - baseS, 1);
    chk("t3.pulsesW", upCnt[1] - baseW, 1);
    gs = 2'd0; tick(2);
    gs = 2'd1; tick(2);

    // T4/T5: six strobes; saturate+win vs wrap.
    baseS = upCnt[0]; baseW = upCnt[1];
    repeat (6) strobe();
    chk("t4.dataS", int'(dataS), 4);
    chk("t4.winS", int'(winS), 1);
    chk("t4.pulsesS", upCnt[0] - baseS, 4);
    chk("t5.dataW", int'(dataW), 1);
    chk("t5.winW", int'(winW), 0);
    chk("t5.pulsesW", upCnt[1] - baseW, 6);

    // WIN -> HOLD keeps win; strobes ignored in HOLD.
    gs = 2'd2; tick(2);
    baseS = upCnt[0]; baseW = upCnt[1];
    strobe();
    chk("hold.dataS", int'(dataS), 4);
    chk("hold.winS", int'(winS), 1);
    chk("hold.dataW", int'(dataW), 1);
    chk("hold.pulses", (upCnt[0] - baseS) + (upCnt[1] - baseW), 0);
    gs = 2'd3; tick(2);
    chk("rsvd.dataS", int'(dataS), 0);
    chk("rsvd.winS", int'(winS), 0);
    gs = 2'd1; tick(2);
    strobe();

    // T6: strobe edge in the same cycle as STARTGAME -> ENDGAME.
    baseS = upCnt[0]; baseW = upCnt[1];
    cs = 1'b0; gs = 2'd2; tick(1);
    cs = 1'b1; tick(2);
    chk("t6.dataS", int'(dataS), 1);
    chk("t6.dataW", int'(dataW), 2);
    chk("t6.pulses", (upCnt[0] - baseS) + (upCnt[1] - baseW), 0);
    gs = 2'd1; tick(2);
    gs = 2'd0; tick(2);
    chk("t6.idle.dataS", int'(dataS), 0);
    chk("t6.idle.dataW", int'(dataW), 1);

    // Asynchronous reset mid-game.
    gs = 2'd1; tick(2);
    strobe();
    chk("mid.dataW", int'(dataW), 2);
    rst = 1'b1; #1;
    chk("mid.rst.dataS", int'(dataS), 0);
    chk("mid.rst.dataW", int'(dataW), 0);
    tick(2);
    rst = 1'b0; tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
